// File: rtl/instr_feeder.sv
// Instruction feeder: walks a loadable program RAM from address 0, issuing one
// word per run strobe and waiting for the processor's done before the next.
module instr_feeder #(
  parameter int unsigned           DATA_WIDTH = 16,
  parameter int unsigned           ADDR_WIDTH = 4,
  parameter logic [DATA_WIDTH-1:0] HALT_WORD  = {DATA_WIDTH{1'b1}},
  parameter int unsigned           TIMEOUT    = 255
) (
  input  logic                  clk_50MHz,
  input  logic                  reset,
  input  logic                  load_en,
  input  logic [ADDR_WIDTH-1:0] load_addr,
  input  logic [DATA_WIDTH-1:0] load_data,
  input  logic                  start,
  input  logic                  done,
  output logic [DATA_WIDTH-1:0] DIN,
  output logic                  run,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic                  busy,
  output logic                  halted,
  output logic                  error,
  output logic [ADDR_WIDTH:0]   retired
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
  localparam int unsigned RW    = ADDR_WIDTH + 1;
  localparam int unsigned TW    = $clog2(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_CHECK = 3'd2,
    S_ISSUE = 3'd3,
    S_WAIT  = 3'd4,
    S_HALT  = 3'd5
  } state_t;

  state_t                  state_q;
  logic [DATA_WIDTH-1:0]   ram_q [DEPTH];
  logic [DATA_WIDTH-1:0]   rdata_q;
  logic [DATA_WIDTH-1:0]   din_q;
  logic [ADDR_WIDTH-1:0]   pc_q;
  logic [ADDR_WIDTH-1:0]   pc_d;
  logic [RW-1:0]           retired_q;
  logic [RW-1:0]           retired_d;
  logic [TW-1:0]           timer_q;
  logic                    error_q;
  logic                    busy_c;
  logic                    wr_en_c;
  logic                    last_addr_c;
  logic                    timer_exp_c;

  assign busy_c      = (state_q == S_FETCH) || (state_q == S_CHECK) ||
                       (state_q == S_ISSUE) || (state_q == S_WAIT);
  assign wr_en_c     = load_en && !busy_c;
  assign last_addr_c = (pc_q == ADDR_WIDTH'(DEPTH - 1));
  assign timer_exp_c = (timer_q == TW'(TIMEOUT - 1));

  // Incremented pc and saturating retire count for the WAIT-on-done path
  always_comb begin
    pc_d      = pc_q + ADDR_WIDTH'(1);
    retired_d = retired_q;
    if (retired_q != RW'(DEPTH)) begin
      retired_d = retired_q + RW'(1);
    end
  end

  // Program RAM: no reset, synchronous write and one-cycle read of pc
  always_ff @(posedge clk_50MHz) begin
    if (wr_en_c) begin
      ram_q[load_addr] <= load_data;
    end
    rdata_q <= ram_q[pc_q];
  end

  always_ff @(posedge clk_50MHz) begin
    if (reset) begin
      state_q   <= S_IDLE;
      din_q     <= '0;
      pc_q      <= '0;
      retired_q <= '0;
      timer_q   <= '0;
      error_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_HALT: begin
          // a simultaneous load wins over start
          if (start && !load_en) begin
            pc_q      <= '0;
            retired_q <= '0;
            error_q   <= 1'b0;
            state_q   <= S_FETCH;
          end
        end
        S_FETCH: begin
          state_q <= S_CHECK;
        end
        S_CHECK: begin
          if (rdata_q == HALT_WORD) begin
            state_q <= S_HALT;
          end else begin
            din_q   <= rdata_q;
            state_q <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          timer_q <= '0;
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          if (done) begin
            retired_q <= retired_d;
            if (last_addr_c) begin
              state_q <= S_HALT;
            end else begin
              pc_q    <= pc_d;
              state_q <= S_FETCH;
            end
          end else if (timer_exp_c) begin
            error_q <= 1'b1;
            state_q <= S_HALT;
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign DIN     = din_q;
  assign run     = (state_q == S_ISSUE);
  assign busy    = busy_c;
  assign halted  = (state_q == S_HALT);
  assign pc      = pc_q;
  assign error   = error_q;
  assign retired = retired_q;

endmodule
